vga_vram_arbiter: RTL and testbench

//  Shares one single-port VRAM (1-cycle read latency) between the VGA scanout and the CPU bus.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_wr_buf.sv | 37 +++
 rtl/vga_vram_arbiter.sv | 148 ++++++++++++++
 tb/tb_vga_vram_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA VRAM path: default widths, 640x480 timing constants
// and the CPU read FSM state encoding.
package vga_pkg;

  localparam int ADDR_W_DEF   = 19;
  localparam int DATA_W_DEF   = 12;
  localparam int MAX_WAIT_DEF = 800;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DATA  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/vga_wr_buf.sv
// One-entry posted write buffer: captures a CPU write, holds it until the VRAM port is free.
module vga_wr_buf
  import vga_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              drain,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  // cap only fires with the buffer empty and drain only with it full, so they never collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
    end else if (cap) begin
      wb_valid <= 1'b1;
    end else if (drain) begin
      wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      wb_addr <= cap_addr;
      wb_data <= cap_data;
    end
  end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: scanout fetches own the port whenever requested, the CPU
// (posted writes, then reads) fills the remaining cycles.
module vga_vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              starve,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(MAX_WAIT)) ? v : v + CNT_W'(1);
  endfunction

  rd_state_t         state;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wr_cap;
  logic              wr_drain;
  logic              rd_start;
  logic              rd_issue;
  logic              vld_p1;
  logic              vld_p2;
  logic [DATA_W-1:0] pix_data_p2;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_nxt;

  // A request is not looked at in its own ack cycle, so one request yields exactly one ack
  assign wr_cap   = cpu_req & cpu_we & ~wb_valid & (state == IDLE) & ~cpu_ack;
  assign rd_start = cpu_req & ~cpu_we & ~wb_valid & (state == IDLE) & ~cpu_ack;
  assign wr_drain = wb_valid & ~pix_req;
  assign rd_issue = (state == RD_ISSUE) & ~pix_req & ~wb_valid;

  vga_wr_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap      (wr_cap),
    .cap_addr (cpu_addr),
    .cap_data (cpu_wdata),
    .drain    (wr_drain),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data)
  );

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (pix_req) begin
      ram_en   = 1'b1;
      ram_addr = pix_addr;
    end else if (wb_valid) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = wb_addr;
      ram_wdata = wb_data;
    end else if (rd_issue) begin
      ram_en   = 1'b1;
      ram_addr = cpu_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rd_start) begin
            state <= RD_ISSUE;
          end else if (wr_cap) begin
            cpu_ack <= 1'b1;
          end
        end
        RD_ISSUE: begin
          if (rd_issue) begin
            state <= RD_DATA;
          end
        end
        RD_DATA: begin
          cpu_rdata <= ram_rdata;
          cpu_ack   <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // p1: RAM read in flight; p2: fetched pixel registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      pix_data_p2 <= '0;
    end else begin
      vld_p1      <= pix_req;
      vld_p2      <= vld_p1;
      pix_data_p2 <= vld_p1 ? ram_rdata : '0;
    end
  end

  assign pix_valid = vld_p2;
  assign pix_data  = pix_data_p2;

  assign wait_nxt = cpu_ack ? '0 : (cpu_req ? sat_inc(wait_cnt) : wait_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      starve   <= starve | (wait_nxt == CNT_W'(MAX_WAIT));
    end
  end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Scoreboard bench for vga_vram_arbiter: directed stimulus pushes expectations, a negedge
// monitor checks pixels, CPU acks and RAM writes as they appear.
module tb_vga_vram_arbiter;

  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 12;
  localparam int MAX_WAIT = 800;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              pix_req = 1'b0;
  logic [ADDR_W-1:0] pix_addr = '0;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              starve;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;

  vga_vram_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_req   (pix_req),
    .pix_addr  (pix_addr),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .starve    (starve),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  bit skip_pix = 1'b0;

  typedef struct { logic [DATA_W-1:0] data; int at; } pix_exp_t;
  typedef struct { logic we; logic [DATA_W-1:0] rdata; int at; } cpu_exp_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; int at; } wr_exp_t;

  pix_exp_t pix_q[$];
  cpu_exp_t cpu_q[$];
  wr_exp_t  wr_q[$];

  // VRAM model: preloaded with data = low bits of address, overridden by writes
  logic [DATA_W-1:0] wmem [logic [ADDR_W-1:0]];

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    if (wmem.exists(a)) return wmem[a];
    return a[DATA_W-1:0];
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) wmem[ram_addr] = ram_wdata;
      else ram_rdata <= mem_rd(ram_addr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_data"}, pix_data, 0);
    chk({tag, "_cpu_ack"}, cpu_ack, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
    chk({tag, "_starve"}, starve, 0);
    chk({tag, "_ram_en"}, ram_en, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
  endtask

  task automatic clear_inputs();
    pix_req = 1'b0; pix_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  // Pixel addresses used never collide with CPU-written ones, so expected data = address
  task automatic pix_run(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      pix_exp_t e;
      pix_req  = 1'b1;
      pix_addr = ADDR_W'(base + i);
      e.data = DATA_W'(base + i);
      e.at   = cyc + 2;
      pix_q.push_back(e);
      tick();
    end
    pix_req  = 1'b0;
    pix_addr = '0;
  endtask

  // exp_rd is the read data for reads, or the still-held previous read value for writes
  task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input int ack_lat, input int wr_lat, input logic [DATA_W-1:0] exp_rd);
    cpu_exp_t ce;
    wr_exp_t  we_e;
    int       t0;
    int       n;
    t0 = cyc;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    ce.we = we; ce.rdata = exp_rd; ce.at = t0 + ack_lat;
    cpu_q.push_back(ce);
    if (we) begin
      we_e.addr = a; we_e.data = d; we_e.at = t0 + wr_lat;
      wr_q.push_back(we_e);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (!cpu_ack && n < 2000);
    chk("ack_seen", cpu_ack, 1);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (!skip_pix) begin
        if (pix_valid) begin
          if (pix_q.size() == 0) chk("pix_unexpected", 1, 0);
          else begin
            pix_exp_t pe;
            pe = pix_q.pop_front();
            chk("pix_data", pix_data, pe.data);
            chk("pix_cycle", cyc, pe.at);
          end
        end else begin
          chk("pix_idle_zero", pix_data, 0);
        end
      end
      if (cpu_ack) begin
        if (cpu_q.size() == 0) chk("ack_unexpected", 1, 0);
        else begin
          cpu_exp_t ae;
          ae = cpu_q.pop_front();
          chk("ack_cycle", cyc, ae.at);
          chk("cpu_rdata", cpu_rdata, ae.rdata);
        end
      end
      if (ram_en && ram_we) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          wr_exp_t wx;
          wx = wr_q.pop_front();
          chk("wr_addr", 32'(ram_addr), 32'(wx.addr));
          chk("wr_data", ram_wdata, wx.data);
          chk("wr_cycle", cyc, wx.at);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk_zero("rst");
    rst_n = 1'b1;
    tick();

    // Full visible line of back-to-back fetches
    pix_run(0, 640);
    repeat (4) tick();

    // Blanking write then read-back
    cpu_op(1'b1, 19'h19000, 12'hABC, 1, 1, 12'h000);
    cpu_op(1'b0, 19'h19000, 12'h000, 3, 0, 12'hABC);
    repeat (3) tick();

    // Write during active pixels: drains at the first free cycle (c0+20)
    fork
      pix_run(100, 20);
      begin
        repeat (5) tick();
        cpu_op(1'b1, 19'h1F000, 12'h123, 1, 15, 12'hABC);
      end
    join
    repeat (4) tick();
    cpu_op(1'b0, 19'h1F000, 12'h000, 3, 0, 12'h123);

    // Write then read of the same address behind a busy line
    fork
      pix_run(200, 30);
      begin
        repeat (2) tick();
        cpu_op(1'b1, 19'h1F000, 12'h456, 1, 28, 12'h123);
        cpu_op(1'b0, 19'h1F000, 12'h000, 30, 0, 12'h456);
      end
    join
    repeat (3) tick();

    // Starvation: read held off by 805 fetch cycles
    chk("starve_pre", starve, 0);
    fork
      pix_run(300, 805);
      cpu_op(1'b0, 19'h00005, 12'h000, 807, 0, 12'h005);
      begin
        repeat (798) tick();
        chk("starve_798", starve, 0);
        repeat (2) tick();
        chk("starve_800", starve, 1);
      end
    join
    repeat (2) tick();
    chk("starve_sticky", starve, 1);
    repeat (3) tick();

    // Reset while a posted write is pending
    skip_pix = 1'b1;
    pix_req = 1'b1; pix_addr = 19'h00010;
    begin
      cpu_exp_t e;
      e.we = 1'b1; e.rdata = 12'h005; e.at = cyc + 1;
      cpu_q.push_back(e);
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h1F100; cpu_wdata = 12'h777;
    tick();
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    #2;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk_zero("rst_wb");
    repeat (2) tick();
    chk_zero("rst_wb_hold");
    rst_n = 1'b1;
    repeat (6) tick();
    skip_pix = 1'b0;
    cpu_op(1'b0, 19'h1F100, 12'h000, 3, 0, 12'h100);
    repeat (2) tick();

    // Reset while a read waits in RD_ISSUE
    skip_pix = 1'b1;
    pix_req = 1'b1; pix_addr = 19'h00020;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00040;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk_zero("rst_rd");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    skip_pix = 1'b0;
    chk("rd_after_rst_rdata", cpu_rdata, 0);

    chk("pixq_empty", pix_q.size(), 0);
    chk("cpuq_empty", cpu_q.size(), 0);
    chk("wrq_empty", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
